// File: rtl/foc_enc_tx.sv
// FOC transmit encoder: each 4-bit nibble maps to a 5-bit crosstalk-avoiding codeword.
// Registered output stage with a one-entry skid buffer, valid/ready on both sides.
module foc_enc_tx #(
   parameter int LANES = 2,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*LANES-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [5*LANES-1:0]   out_data,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     word_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [4:0] f_enc_nib(input logic [3:0] nib);
      logic [4:0] cw;
      case (nib)
         4'h0: cw = 5'b00000;
         4'h1: cw = 5'b00100;
         4'h2: cw = 5'b00001;
         4'h3: cw = 5'b00101;
         4'h4: cw = 5'b00011;
         4'h5: cw = 5'b00111;
         4'h6: cw = 5'b10011;
         4'h7: cw = 5'b10111;
         4'h8: cw = 5'b10000;
         4'h9: cw = 5'b10100;
         4'hA: cw = 5'b10001;
         4'hB: cw = 5'b10101;
         4'hC: cw = 5'b11000;
         4'hD: cw = 5'b11100;
         4'hE: cw = 5'b11001;
         4'hF: cw = 5'b11101;
         default: cw = 5'b00000;
      endcase
      return cw;
   endfunction

   logic [5*LANES-1:0] r_or_data;
   logic               r_or_vld;
   logic [5*LANES-1:0] r_sk_data;
   logic               r_sk_vld;
   logic [CNT_W-1:0]   r_cnt;

   logic [5*LANES-1:0] w_enc;
   logic               w_accept;
   logic               w_pop;

   always_comb begin
      w_enc = '0;
      for (int k = 0; k < LANES; k++) begin
         w_enc[5*k +: 5] = f_enc_nib(in_data[4*k +: 4]);
      end
   end

   // in_ready comes straight from the skid flag, so it never depends on out_ready.
   assign w_accept  = in_valid & ~r_sk_vld;
   assign w_pop     = r_or_vld & out_ready;

   // Data is only loaded on an accept, so a don't-care in_data while idle never reaches the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_or_data <= '0;
         r_or_vld  <= 1'b0;
         r_sk_data <= '0;
         r_sk_vld  <= 1'b0;
      end else if (w_pop && r_sk_vld) begin
         r_or_data <= r_sk_data;
         r_sk_vld  <= 1'b0;
      end else if (w_accept && (!r_or_vld || w_pop)) begin
         r_or_data <= w_enc;
         r_or_vld  <= 1'b1;
      end else if (w_accept) begin
         r_sk_data <= w_enc;
         r_sk_vld  <= 1'b1;
      end else if (w_pop) begin
         r_or_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (w_pop && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign in_ready  = ~r_sk_vld;
   assign out_valid = r_or_vld;
   assign out_data  = r_or_data;
   assign word_cnt  = r_cnt;

endmodule
